// File: rtl/riscv_divider.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One quotient bit per cycle; special cases resolve at issue without iterating.
module riscv_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       op_q, op_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Operand conditioning at issue
  logic             signed_op, a_neg, b_neg, is_zero, is_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & dividend[WIDTH-1];
  assign b_neg     = signed_op & divisor[WIDTH-1];
  assign a_mag     = a_neg ? -dividend : dividend;
  assign b_mag     = b_neg ? -divisor  : divisor;
  assign is_zero   = (divisor == '0);
  assign is_ovf    = signed_op && (dividend == SMIN) && (divisor == '1);

  // One restoring step: shift {R,Q} left, trial-subtract in WIDTH+1 bits
  logic [WIDTH:0] shifted, trial;

  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr_q};

  // The partial remainder stays below the divisor, so its top bit is always 0.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[WIDTH];

  logic [WIDTH-1:0] q_fin, r_fin;

  assign q_fin = negq_q ? -quo_q : quo_q;
  assign r_fin = negr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    res_d   = res_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_d = op;
            if (is_zero) begin
              res_d  = op[1] ? dividend : '1;
              dbz_d  = 1'b1;
              ovf_d  = 1'b0;
              done_d = 1'b1;
            end else if (is_ovf) begin
              res_d  = op[1] ? '0 : dividend;
              dbz_d  = 1'b0;
              ovf_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              state_d = CALC;
              cnt_d   = CW'(WIDTH);
              rem_d   = '0;
              quo_d   = a_mag;
              dsr_d   = b_mag;
              negq_d  = a_neg ^ b_neg;
              negr_d  = a_neg;
            end
          end
        end
        CALC: begin
          rem_d = trial[WIDTH] ? shifted : trial;
          quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = FIX;
        end
        FIX: begin
          res_d   = op_q[1] ? r_fin : q_fin;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      res_q   <= res_d;
      op_q    <= op_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign result      = res_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/riscv_divider.md
Name: riscv_divider

Overview:
- Parametrised iterative restoring divider for the RISC-V M-extension divide unit: DIV, DIVU, REM and REMU.
- Sits beside the ALU in EX.
- The pipeline stalls while busy is high and captures result on the done pulse.
- Generalises the 8-bit unsigned divider with:
  - configurable width
  - signed operation
  - RISC-V-exact divide-by-zero and overflow results
  - abort (flush) input
  - back-to-back issue

Parameters:
WIDTH, 32, operand/result width in bits; legal values 8..64, must be even.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
op  input  2  00=DIV (signed quotient), 01=DIVU, 10=REM (signed remainder), 11=REMU
dividend  input  WIDTH  rs1 operand, sampled with start
divisor  input  WIDTH  rs2 operand, sampled with start
abort  input  1  pipeline flush; cancels an in-flight operation
busy  output  1  operation in flight; start is ignored while high
done  output  1  one-cycle pulse; result valid from this cycle
result  output  WIDTH  quotient or remainder, selected by latched op
div_by_zero  output  1  last completed operation had divisor==0
overflow  output  1  last completed operation was signed MIN / -1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM returns to IDLE.
  - busy=0, done=0, result=0, div_by_zero=0, overflow=0.
  - Internal counter and registers are cleared.
- FSM states:
  - IDLE -> CALC on start with a normal operation.
  - IDLE -> IDLE on start with a special case; done is still produced.
  - CALC -> FIX when the iteration counter reaches zero.
  - FIX -> IDLE, asserting done.
- Signed ops (op[0]=0) take operand magnitudes on entry.
  - Latched negation flags:
    - Quotient sign = sign(dividend) XOR sign(divisor).
    - Remainder sign = sign(dividend).
- CALC iteration (one per cycle, WIDTH iterations):
  - Shift {R,Q} left by 1.
  - Trial subtract of divisor magnitude in WIDTH+1 bits.
  - If the sign bit is set: restore, Q[0]=0. Otherwise keep the difference, Q[0]=1.
- FIX: apply negation flags (two's complement), select quotient or remainder by op[1], register result, assert done.
- Latency, normal op: start sampled at edge 0; done=1 and result valid in the cycle after edge WIDTH+1 (WIDTH+2 cycles).
- busy:
  - Rises the cycle after start is accepted.
  - Is 1 through CALC and FIX.
  - Falls in the same cycle done rises.
- Special cases (decided at start, no iteration), done one cycle after start:
  - Divisor==0: quotient = all ones (DIV/DIVU); remainder = dividend (REM/REMU); div_by_zero=1.
  - Signed op with dividend=100..0 and divisor=all ones: quotient = dividend (MIN); remainder = 0; overflow=1.
  - For DIVU/REMU the MIN / -1 pattern is a normal unsigned divide.
- Flags are updated on every completion (cleared for normal ops) and held until the next completion.
- result and flags hold their value until the next done, or until reset.
- done is high for exactly one cycle. In that cycle FSM=IDLE, so a start in the same cycle is accepted (back-to-back issue, no bubble).
- start while busy=1: ignored; operands are not re-sampled.
- abort:
  - Synchronous, highest priority after reset.
  - In CALC/FIX: FSM goes to IDLE at the next edge, busy=0, no done, result/flags unchanged.
  - In IDLE with start: start is dropped.
  - Abort in the same cycle a special-case start would complete: dropped, no done.
- Counter width is $clog2(WIDTH+1). The remainder register is WIDTH+1 bits; only [WIDTH-1:0] is ever exposed.

Test Plan:
1. WIDTH=8, DIVU 25/4, then REMU 25/4 issued in the done cycle -> result 6 (done at cycle 10 after start), then 1 with no bubble; flags 0.
2. WIDTH=32, DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. REM 7/-2 -> 1. DIV -8/-2 -> 4. Each has done at WIDTH+2=34 cycles.
3. WIDTH=32, DIVU 123/0 -> 0xFFFFFFFF, div_by_zero=1, done 1 cycle after start. Then REM 123/0 -> 123. Then DIVU 9/3 -> 3 with div_by_zero cleared.
4. WIDTH=32, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, overflow=1. REM same operands -> 0. DIVU same operands -> 0 in 34 cycles, overflow=0.
5. Assert abort at cycle 5 of CALC -> busy=0 next cycle, no done, result unchanged. A start pulsed mid-operation is ignored and its operands do not affect the in-flight result.
6. Drop rst_n asynchronously mid-CALC (between edges) -> busy/done/result/flags read 0 immediately. After release, DIVU 255/2 -> 127.
